// File: rtl/pattern_mode_sched_if.sv
// Handshake bundle between the mode scheduler, the key pin, the timing
// generator and the pattern generator. The slave modport is the scheduler's view.
interface pattern_mode_sched_if;
  logic       I_key;
  logic       I_vs;
  logic       I_ack;
  logic [2:0] O_mode;
  logic       O_req;
  logic       O_dir;
  logic       O_busy;

  modport slave (
    input  I_key,
    input  I_vs,
    input  I_ack,
    output O_mode,
    output O_req,
    output O_dir,
    output O_busy
  );

  modport master (
    output I_key,
    output I_vs,
    output I_ack,
    input  O_mode,
    input  O_req,
    input  O_dir,
    input  O_busy
  );
endinterface

// File: rtl/pattern_mode_sched.sv
// Key-driven ping-pong mode scheduler committing on vsync via req/ack.
// Optional KEY_REPEAT_EN adds auto-repeat presses while the key is held.
module pattern_mode_sched #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int DB_W            = 20,
  parameter int MODE_MAX        = 5,
  parameter int REPEAT_CYCLES   = 13500000
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  pattern_mode_sched_if.slave   bus
);

  if ((64'd1 << DB_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_db_w
    $error("DB_W too small for DEBOUNCE_CYCLES");
  end
  if (MODE_MAX < 1 || MODE_MAX > 7) begin : g_bad_mode_max
    $error("MODE_MAX must be within 1..7");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    REQ     = 2'd2
  } state_t;

  localparam logic [2:0]      MAX_IDX = 3'(MODE_MAX);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            key_s1;
  logic            key_s2;
  logic            key_db;
  logic            key_db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            vs_prev;
  logic            vs_rise;
  logic [2:0]      pend;
  logic            dir;
  logic            dirty;
  logic [2:0]      mode_q;
  logic            req_q;
  state_t          state_q;
  state_t          state_d;
  logic            commit;
  logic            ack_done;

  // Key is asynchronous, so it is synchronised before the debounce counter.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      key_s1      <= 1'b0;
      key_s2      <= 1'b0;
      key_db      <= 1'b0;
      key_db_prev <= 1'b0;
      db_cnt      <= '0;
    end else begin
      key_s1      <= bus.I_key;
      key_s2      <= key_s1;
      key_db_prev <= key_db;
      if (key_s2 != key_db) begin
        if (db_cnt == DB_LAST) begin
          key_db <= key_s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] hold_cnt;
  logic            rep_tick;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      hold_cnt <= '0;
    end else if (!key_db || hold_cnt == RP_LAST) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign rep_tick = key_db && (hold_cnt == RP_LAST);
  assign press    = (key_db & ~key_db_prev) | rep_tick;
`else
  assign press = key_db & ~key_db_prev;
`endif

  assign vs_rise = bus.I_vs & ~vs_prev;

  // A press coinciding with a commit keeps dirty set so the next frame commits again.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      vs_prev <= 1'b0;
      pend    <= 3'd0;
      dir     <= 1'b1;
      dirty   <= 1'b0;
    end else begin
      vs_prev <= bus.I_vs;
      if (press) begin
        dirty <= 1'b1;
        if (dir && pend == MAX_IDX) begin
          pend <= MAX_IDX - 3'd1;
          dir  <= 1'b0;
        end else if (!dir && pend == 3'd0) begin
          pend <= 3'd1;
          dir  <= 1'b1;
        end else if (dir) begin
          pend <= pend + 3'd1;
        end else begin
          pend <= pend - 3'd1;
        end
      end else if (commit) begin
        dirty <= 1'b0;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= IDLE;
      mode_q  <= 3'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        mode_q <= pend;
        req_q  <= 1'b1;
      end else if (ack_done) begin
        req_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    ack_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (dirty) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) begin
          commit  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.I_ack) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.O_mode = mode_q;
  assign bus.O_req  = req_q;
  assign bus.O_dir  = dir;
  assign bus.O_busy = dirty | (state_q != IDLE);

endmodule

// File: tb/tb_pattern_mode_sched.sv
// Self-checking bench for pattern_mode_sched: table-driven frames, corner
// sequences and a randomized phase against a closed-form ping-pong model.
module tb_pattern_mode_sched;

  localparam int DEB = 4;
  localparam int MM  = 5;

  typedef struct {
    int presses;
    int exp_mode;
    int exp_dir;
    int exp_reqs;
  } vec_t;

  logic clk;
  logic rst;
  logic ack_en;
  logic ack_d;
  int   checks;
  int   failures;
  int   n_press;
  int   req_pulses;
  logic req_prev;
  vec_t vecs[12];

  pattern_mode_sched_if bus ();

  pattern_mode_sched #(
    .DEBOUNCE_CYCLES(DEB),
    .DB_W(3),
    .MODE_MAX(MM),
    .REPEAT_CYCLES(13500000)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern generator stand-in: acknowledges one cycle after seeing req.
  always @(posedge clk) ack_d <= bus.O_req;
  assign bus.I_ack = ack_en & ack_d;

  always @(negedge clk) begin
    if (bus.O_req && !req_prev) req_pulses++;
    req_prev = bus.O_req;
  end

  // Ping-pong index after n presses from reset: a triangle wave of period 2*MM.
  function automatic int mdl_pend(int n);
    int k = n % (2 * MM);
    return (k <= MM) ? k : 2 * MM - k;
  endfunction

  function automatic int mdl_dir(int n);
    int k = n % (2 * MM);
    if (n == 0) return 1;
    return (k >= 1 && k <= MM) ? 1 : 0;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic press_key();
    bus.I_key = 1'b1;
    repeat (8) @(negedge clk);
    bus.I_key = 1'b0;
    repeat (8) @(negedge clk);
    n_press++;
  endtask

  task automatic vsync_frame();
    bus.I_vs = 1'b1;
    repeat (2) @(negedge clk);
    bus.I_vs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_req(logic level, int limit, string name);
    int i;
    for (i = 0; i < limit && bus.O_req != level; i++) @(negedge clk);
    check(name, int'(bus.O_req), int'(level));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_press = 0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    int old_mode;
    int nk;

    checks = 0; failures = 0; n_press = 0; req_pulses = 0; req_prev = 1'b0;
    ack_en = 1'b1;
    bus.I_key = 1'b0;
    bus.I_vs  = 1'b0;

    vecs[0]  = '{1, 1, 1, 1};
    vecs[1]  = '{1, 2, 1, 1};
    vecs[2]  = '{1, 3, 1, 1};
    vecs[3]  = '{1, 4, 1, 1};
    vecs[4]  = '{1, 5, 1, 1};
    vecs[5]  = '{1, 4, 0, 1};
    vecs[6]  = '{1, 3, 0, 1};
    vecs[7]  = '{1, 2, 0, 1};
    vecs[8]  = '{1, 1, 0, 1};
    vecs[9]  = '{1, 0, 0, 1};
    vecs[10] = '{1, 1, 1, 1};
    vecs[11] = '{0, 1, 1, 0};

    @(negedge clk);
    do_reset();
    check("reset_mode", int'(bus.O_mode), 0);
    check("reset_req",  int'(bus.O_req),  0);
    check("reset_dir",  int'(bus.O_dir),  1);
    check("reset_busy", int'(bus.O_busy), 0);

    // Short glitch must not pass the debouncer.
    base = req_pulses;
    bus.I_key = 1'b1;
    repeat (3) @(negedge clk);
    bus.I_key = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", int'(bus.O_busy), 0);
    vsync_frame();
    check("glitch_mode", int'(bus.O_mode), 0);
    check("glitch_reqs", req_pulses - base, 0);

    for (int v = 0; v < 12; v++) begin
      base = req_pulses;
      for (int p = 0; p < vecs[v].presses; p++) press_key();
      vsync_frame();
      check($sformatf("vec%0d_mode", v), int'(bus.O_mode), vecs[v].exp_mode);
      check($sformatf("vec%0d_dir", v),  int'(bus.O_dir),  vecs[v].exp_dir);
      check($sformatf("vec%0d_reqs", v), req_pulses - base, vecs[v].exp_reqs);
      check($sformatf("vec%0d_busy", v), int'(bus.O_busy), 0);
    end

    // Three presses in one frame from mode 0 collapse into one commit.
    do_reset();
    base = req_pulses;
    repeat (3) press_key();
    check("burst_busy_pending", int'(bus.O_busy), 1);
    check("burst_mode_before",  int'(bus.O_mode), 0);
    vsync_frame();
    check("burst_mode", int'(bus.O_mode), 3);
    check("burst_reqs", req_pulses - base, 1);

    // Press pulse lands on the same edge as vs_rise.
    press_key();
    old_mode = mdl_pend(n_press);
    bus.I_key = 1'b1;
    repeat (6) @(negedge clk);
    bus.I_vs = 1'b1;
    @(negedge clk);
    n_press++;
    check("coincide_old_mode", int'(bus.O_mode), old_mode);
    check("coincide_busy",     int'(bus.O_busy), 1);
    bus.I_vs  = 1'b0;
    bus.I_key = 1'b0;
    repeat (12) @(negedge clk);
    check("coincide_busy_after", int'(bus.O_busy), 1);
    vsync_frame();
    check("coincide_new_mode", int'(bus.O_mode), mdl_pend(n_press));

    // Delayed acknowledge with a press arriving while req is outstanding.
    ack_en = 1'b0;
    press_key();
    old_mode = mdl_pend(n_press);
    bus.I_vs = 1'b1;
    @(negedge clk);
    bus.I_vs = 1'b0;
    wait_req(1'b1, 5, "hold_req_rise");
    repeat (20) @(negedge clk);
    press_key();
    repeat (14) @(negedge clk);
    check("hold_req_high",   int'(bus.O_req),  1);
    check("hold_mode_stable", int'(bus.O_mode), old_mode);
    ack_en = 1'b1;
    wait_req(1'b0, 5, "hold_req_fall");
    check("hold_mode_after_ack", int'(bus.O_mode), old_mode);
    check("hold_busy_dirty",     int'(bus.O_busy), 1);
    repeat (5) @(negedge clk);
    vsync_frame();
    check("hold_next_commit", int'(bus.O_mode), mdl_pend(n_press));

    // Asynchronous reset while the handshake is open.
    ack_en = 1'b0;
    press_key();
    bus.I_vs = 1'b1;
    @(negedge clk);
    bus.I_vs = 1'b0;
    wait_req(1'b1, 5, "rst_req_rise");
    rst = 1'b1;
    #1;
    check("rst_async_req",  int'(bus.O_req),  0);
    check("rst_async_mode", int'(bus.O_mode), 0);
    check("rst_async_dir",  int'(bus.O_dir),  1);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    n_press = 0;
    @(negedge clk);
    check("rst_busy", int'(bus.O_busy), 0);

    // Randomized frames against the closed-form model.
    for (int f = 0; f < 15; f++) begin
      base = req_pulses;
      old_mode = int'(bus.O_mode);
      nk = $urandom_range(0, 3);
      for (int p = 0; p < nk; p++) begin
        press_key();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      vsync_frame();
      check($sformatf("rnd%0d_mode", f), int'(bus.O_mode),
            (nk > 0) ? mdl_pend(n_press) : old_mode);
      check($sformatf("rnd%0d_dir", f),  int'(bus.O_dir), mdl_dir(n_press));
      check($sformatf("rnd%0d_reqs", f), req_pulses - base, (nk > 0) ? 1 : 0);
      check($sformatf("rnd%0d_busy", f), int'(bus.O_busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
